addsub_seq_ctrl: RTL

Multi-precision operand sequencer that sits directly upstream of the 8-bit `adder_sub` datapath. It accepts a wide add/subtract request over a valid/ready handshake and slices both operands into bytes. It drives `adder_sub` one byte per cycle, least-significant byte first, chaining `carry_out` into the next `carry_in`. It then assembles the wide result and presents it on a valid/ready output port.

---
 rtl/addsub_seq_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/addsub_seq_ctrl.sv
// rtl/addsub_seq_ctrl.sv - byte-serial wide add/sub sequencer driving an 8-bit adder_sub datapath
// Define ADDSUB_SEQ_FLAGS_EN to add the registered o_out_zero / o_out_ovf result flags.
module addsub_seq_ctrl #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_a,
  input  logic [W-1:0] i_in_b,
  input  logic         i_in_sub,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_result,
  output logic         o_out_carry,
  output logic [7:0]   o_au_a,
  output logic [7:0]   o_au_b,
  output logic         o_au_add_en,
  output logic         o_au_sub_en,
  output logic         o_au_carry_in,
  input  logic [7:0]   i_au_data_out,
  input  logic         i_au_carry_out,
  input  logic         i_au_out_en
`ifdef ADDSUB_SEQ_FLAGS_EN
  ,
  output logic         o_out_zero,
  output logic         o_out_ovf
`endif
);

  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_result;
  logic          r_sub;
  logic          r_carry;
  logic          r_out_carry;
  logic [IW-1:0] r_idx;
  logic          w_accept;
  logic          w_byte_done;
  logic          w_last;

  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Outputs are also forced to their idle values while reset is held.
  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_byte_done   = 1'b0;
    o_in_ready    = 1'b0;
    o_out_valid   = 1'b0;
    o_au_a        = 8'd0;
    o_au_b        = 8'd0;
    o_au_add_en   = 1'b0;
    o_au_sub_en   = 1'b0;
    o_au_carry_in = 1'b0;
    o_out_result  = i_reset ? '0 : r_result;
    o_out_carry   = i_reset ? 1'b0 : r_out_carry;
    case (r_state)
      S_IDLE: begin
        o_in_ready = !i_reset;
        if (i_in_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!i_reset) begin
          o_au_a        = r_a[8*r_idx +: 8];
          o_au_b        = r_b[8*r_idx +: 8];
          o_au_add_en   = !r_sub;
          o_au_sub_en   = r_sub;
          o_au_carry_in = r_carry;
        end
        if (i_au_out_en) begin
          w_byte_done = 1'b1;
          if (w_last) w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        o_out_valid = !i_reset;
        if (i_out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

`ifdef ADDSUB_SEQ_FLAGS_EN
  logic         r_zero;
  logic         r_ovf;
  logic [W-1:0] w_final;
  logic         w_ovf;

  // The last byte written is always the top byte, so the full result is known here.
  assign w_final = {i_au_data_out, r_result[W-9:0]};
  assign w_ovf   = (r_sub ? (r_a[W-1] != r_b[W-1]) : (r_a[W-1] == r_b[W-1]))
                   && (w_final[W-1] != r_a[W-1]);
  assign o_out_zero = i_reset ? 1'b0 : r_zero;
  assign o_out_ovf  = i_reset ? 1'b0 : r_ovf;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_sub       <= 1'b0;
      r_carry     <= 1'b0;
      r_out_carry <= 1'b0;
      r_idx       <= '0;
`ifdef ADDSUB_SEQ_FLAGS_EN
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_a     <= i_in_a;
        r_b     <= i_in_b;
        r_sub   <= i_in_sub;
        r_idx   <= '0;
        r_carry <= i_in_sub;
      end
      if (w_byte_done) begin
        r_result[8*r_idx +: 8] <= i_au_data_out;
        r_carry                <= i_au_carry_out;
        if (w_last) begin
          r_out_carry <= i_au_carry_out;
`ifdef ADDSUB_SEQ_FLAGS_EN
          r_zero      <= (w_final == '0);
          r_ovf       <= w_ovf;
`endif
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

endmodule
